la_cmd_regs: RTL

Host-command front end for the logic analyser capture path. It parses a byte stream from a UART receiver into framed commands and holds the capture parameters driven into the sample controller: chn_sel, mode_sel, freq_sel, pre_num and trigger_en. It arms and disarms capture, watches the controller's finished flag, and returns one reply byte per frame over a valid/ready transmit handshake. All logic runs in the sys_clk domain, the same domain as the sample controller and clock-enable divider.

---
 rtl/la_cmd_pkg.sv | 52 +++++
 rtl/la_byte_timer.sv | 37 +++
 rtl/la_cmd_regs.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/la_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module : la_cmd_pkg
// Brief  : Frame constants, opcodes, reply codes and FSM state type for the
//          logic-analyser host command front end.
// Rev    : 1.0  initial release
// ============================================================================
package la_cmd_pkg;

    localparam logic [7:0] c_hdr       = 8'hA5;

    localparam logic [7:0] c_op_chn    = 8'h01;
    localparam logic [7:0] c_op_mode   = 8'h02;
    localparam logic [7:0] c_op_freq   = 8'h03;
    localparam logic [7:0] c_op_pre    = 8'h04;
    localparam logic [7:0] c_op_arm    = 8'h10;
    localparam logic [7:0] c_op_stop   = 8'h11;
    localparam logic [7:0] c_op_status = 8'h20;

    localparam logic [7:0] c_ack       = 8'h06;
    localparam logic [7:0] c_nak       = 8'h15;

    localparam logic [7:0] c_mode_max  = 8'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_PAY0  = 3'd2,
        ST_PAY1  = 3'd3,
        ST_CSUM  = 3'd4,
        ST_EXEC  = 3'd5,
        ST_REPLY = 3'd6
    } cmd_state_t;

    function automatic logic op_known(input logic [7:0] op);
        case (op)
            c_op_chn, c_op_mode, c_op_freq, c_op_pre,
            c_op_arm, c_op_stop, c_op_status: op_known = 1'b1;
            default:                          op_known = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_pay_len(input logic [7:0] op);
        case (op)
            c_op_chn, c_op_mode, c_op_freq: op_pay_len = 2'd1;
            c_op_pre:                       op_pay_len = 2'd2;
            default:                        op_pay_len = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/la_byte_timer.sv
`default_nettype none
// ============================================================================
// Module : la_byte_timer
// Brief  : Inter-byte timeout counter; fires after TIMEOUT_CYC enabled cycles
//          with no clear.
// Rev    : 1.0  initial release
// ============================================================================
module la_byte_timer #(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] c_last = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != c_last) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // A byte arriving in the last cycle still rescues the frame.
    assign o_timeout = i_en && !i_clr && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/la_cmd_regs.sv
`default_nettype none
// ============================================================================
// Module : la_cmd_regs
// Brief  : Parses framed host commands from the UART byte stream, holds the
//          capture parameters and arm state, returns one reply per frame.
// Rev    : 1.0  initial release
// ============================================================================
module la_cmd_regs
    import la_cmd_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int PRE_DEFAULT = 512,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic       finished,
    output logic       trigger_en,
    output logic [2:0] chn_sel,
    output logic [2:0] mode_sel,
    output logic [3:0] freq_sel,
    output logic [9:0] pre_num
);

    localparam logic [16:0] c_depth       = 17'(DEPTH);
    localparam logic [9:0]  c_pre_default = 10'(PRE_DEFAULT);

    cmd_state_t  r_state;
    cmd_state_t  w_state_nxt;

    logic [7:0]  r_op;
    logic [7:0]  r_pay0;
    logic [7:0]  r_pay1;
    logic [7:0]  r_xor;
    logic        r_nak;
    logic [7:0]  r_tx_data;
    logic        r_tx_valid;
    logic        r_trigger_en;
    logic        r_done;
    logic [2:0]  r_chn_sel;
    logic [2:0]  r_mode_sel;
    logic [3:0]  r_freq_sel;
    logic [9:0]  r_pre_num;
    logic        r_fin_d;
    logic        r_fin_rise;

    logic        w_timer_en;
    logic        w_timeout;
    logic        w_ack;
    logic        w_exec_ack;
    logic [7:0]  w_reply;
    logic [15:0] w_pre_val;

    assign w_timer_en = (r_state == ST_CMD) || (r_state == ST_PAY0) ||
                        (r_state == ST_PAY1) || (r_state == ST_CSUM);
    assign w_pre_val  = {r_pay0, r_pay1};
    assign w_exec_ack = (r_state == ST_EXEC) && w_ack;

    la_byte_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_byte_timer (
        .clk       (sys_clk),
        .rst_n     (sys_rst_n),
        .i_clr     (rx_valid),
        .i_en      (w_timer_en),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (rx_valid && (rx_data == c_hdr)) w_state_nxt = ST_CMD;
            end
            ST_CMD: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                end else if (rx_valid) begin
                    if (!op_known(rx_data))             w_state_nxt = ST_EXEC;
                    else if (op_pay_len(rx_data) == 2'd0) w_state_nxt = ST_CSUM;
                    else                                w_state_nxt = ST_PAY0;
                end
            end
            ST_PAY0: begin
                if (w_timeout)                        w_state_nxt = ST_IDLE;
                else if (rx_valid && r_op == c_op_pre) w_state_nxt = ST_PAY1;
                else if (rx_valid)                    w_state_nxt = ST_CSUM;
            end
            ST_PAY1: begin
                if (w_timeout)     w_state_nxt = ST_IDLE;
                else if (rx_valid) w_state_nxt = ST_CSUM;
            end
            ST_CSUM: begin
                if (w_timeout)     w_state_nxt = ST_IDLE;
                else if (rx_valid) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_REPLY;
            end
            ST_REPLY: begin
                if (tx_ready) w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Parameter writes are refused while armed so a running capture keeps its setup.
    always_comb begin
        w_ack   = 1'b0;
        w_reply = c_nak;
        if (!r_nak) begin
            case (r_op)
                c_op_chn, c_op_freq: w_ack = !r_trigger_en;
                c_op_mode:           w_ack = !r_trigger_en && (r_pay0 <= c_mode_max);
                c_op_pre:            w_ack = !r_trigger_en && ({1'b0, w_pre_val} < c_depth);
                c_op_arm, c_op_stop,
                c_op_status:         w_ack = 1'b1;
                default:             w_ack = 1'b0;
            endcase
        end
        if (w_ack) begin
            w_reply = (r_op == c_op_status) ? {r_trigger_en, r_done, 6'b0} : c_ack;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_op         <= '0;
            r_pay0       <= '0;
            r_pay1       <= '0;
            r_xor        <= '0;
            r_nak        <= 1'b0;
            r_tx_data    <= '0;
            r_tx_valid   <= 1'b0;
            r_trigger_en <= 1'b0;
            r_done       <= 1'b0;
            r_chn_sel    <= '0;
            r_mode_sel   <= '0;
            r_freq_sel   <= '0;
            r_pre_num    <= c_pre_default;
            r_fin_d      <= 1'b0;
            r_fin_rise   <= 1'b0;
        end else begin
            r_fin_d    <= finished;
            r_fin_rise <= finished & ~r_fin_d;

            if (rx_valid) begin
                case (r_state)
                    ST_CMD: begin
                        r_op  <= rx_data;
                        r_xor <= rx_data;
                        r_nak <= !op_known(rx_data);
                    end
                    ST_PAY0: begin
                        r_pay0 <= rx_data;
                        r_xor  <= r_xor ^ rx_data;
                    end
                    ST_PAY1: begin
                        r_pay1 <= rx_data;
                        r_xor  <= r_xor ^ rx_data;
                    end
                    ST_CSUM: begin
                        if (rx_data != r_xor) r_nak <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            if (r_state == ST_EXEC) begin
                r_tx_data  <= w_reply;
                r_tx_valid <= 1'b1;
            end else if ((r_state == ST_REPLY) && tx_ready) begin
                r_tx_valid <= 1'b0;
            end

            if (w_exec_ack) begin
                case (r_op)
                    c_op_chn:  r_chn_sel  <= r_pay0[2:0];
                    c_op_mode: r_mode_sel <= r_pay0[2:0];
                    c_op_freq: r_freq_sel <= r_pay0[3:0];
                    c_op_pre:  r_pre_num  <= w_pre_val[9:0];
                    default: begin
                    end
                endcase
            end

            // ARM takes priority over a coincident capture-complete edge.
            if (w_exec_ack && (r_op == c_op_arm)) begin
                r_trigger_en <= 1'b1;
                r_done       <= 1'b0;
            end else begin
                if (w_exec_ack && (r_op == c_op_stop)) r_trigger_en <= 1'b0;
                if (r_fin_rise && r_trigger_en) begin
                    r_trigger_en <= 1'b0;
                    r_done       <= 1'b1;
                end
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign trigger_en = r_trigger_en;
    assign chn_sel    = r_chn_sel;
    assign mode_sel   = r_mode_sel;
    assign freq_sel   = r_freq_sel;
    assign pre_num    = r_pre_num;

endmodule
`default_nettype wire
